// File: rtl/fbw_pkg.sv
// Shared types and helpers for the frame-buffer writer.
// Pixel packing, head FSM encoding and the statistics counter width.
package fbw_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    H_EMPTY = 1'b0,
    H_HOLD  = 1'b1
  } head_e;

  function automatic logic [15:0] pack565(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/fbw_fifo.sv
// Synchronous FIFO for the frame-buffer writer.
// Power-of-two depth; pointers wrap naturally, push-while-full needs a pop.
module fbw_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign o_full  = count == CW'(DEPTH);
  assign o_empty = count == '0;
  assign o_count = count;
  assign o_dout  = mem[rd_ptr];
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Packs raster pixels to RGB565, addresses them and queues them to memory.
// Optional FBW_BOUNDS_CHECK_EN discards off-screen pixels in the S1 stage.
module frame_buffer_writer
  import fbw_pkg::*;
#(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int ADDR_BITS = 17,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_pix_valid,
  input  logic signed [15:0]    i_pix_x,
  input  logic signed [15:0]    i_pix_y,
  input  logic [7:0]            i_pix_r,
  input  logic [7:0]            i_pix_g,
  input  logic [7:0]            i_pix_b,
  input  logic                  i_clear_stats,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  output logic [ADDR_BITS-1:0]  o_mem_addr,
  output logic [15:0]           o_mem_data,
  output logic                  o_overflow,
  output logic [CNT_W-1:0]      o_drop_count,
  output logic                  o_idle
);

  localparam int AW2 = ADDR_BITS + 2;
  localparam int FW  = ADDR_BITS + 16;

  logic                    keep_d;
  logic [ADDR_BITS-1:0]    addr_d;
  logic signed [AW2-1:0]   xs;
  logic signed [AW2-1:0]   ys;

  logic                    s1_keep;
  logic [ADDR_BITS-1:0]    s1_addr;
  logic [15:0]             s1_data;

  logic [FW-1:0]           fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;

  head_e                   state_q;
  head_e                   state_d;
  logic                    load;
  logic                    drop;

  assign xs     = AW2'(i_pix_x);
  assign ys     = AW2'(i_pix_y);
  assign addr_d = ADDR_BITS'(AW2'(BASE_ADDR) + ys * AW2'(FB_WIDTH) + xs);

`ifdef FBW_BOUNDS_CHECK_EN
  logic in_range;
  assign in_range = (int'(i_pix_x) >= 0) && (int'(i_pix_x) < FB_WIDTH)
                 && (int'(i_pix_y) >= 0) && (int'(i_pix_y) < FB_HEIGHT);
  assign keep_d = i_pix_valid && in_range;
`else
  assign keep_d = i_pix_valid;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_keep <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
    end else begin
      s1_keep <= keep_d;
      s1_addr <= addr_d;
      s1_data <= pack565(i_pix_r, i_pix_g, i_pix_b);
    end
  end

  fbw_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (s1_keep),
    .i_din     ({s1_addr, s1_data}),
    .i_pop     (load),
    .o_dout    (fifo_dout),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (fifo_count)
  );

  // The head refills from the FIFO on the same edge it hands off a word.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      H_EMPTY: begin
        if (!fifo_empty) begin
          state_d = H_HOLD;
          load    = 1'b1;
        end
      end
      H_HOLD: begin
        if (i_mem_ready) begin
          if (fifo_empty) state_d = H_EMPTY;
          else            load    = 1'b1;
        end
      end
      default: state_d = H_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= H_EMPTY;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        o_mem_addr <= fifo_dout[FW-1:16];
        o_mem_data <= fifo_dout[15:0];
      end
    end
  end

  assign drop = s1_keep && fifo_full && !load;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (i_clear_stats) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_count != '1) o_drop_count <= o_drop_count + CNT_W'(1);
    end
  end

  assign o_mem_valid = state_q == H_HOLD;
  assign o_idle      = !s1_keep && (fifo_count == '0) && (state_q == H_EMPTY);

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer.
// Pixel-timeline model of the queue plus directed literal checks.
module tb_frame_buffer_writer;

  localparam int W  = 320;
  localparam int H  = 240;
  localparam int AB = 17;
  localparam int BA = 0;
  localparam int D  = 16;

  logic               i_clk = 1'b0;
  logic               i_reset_n = 1'b0;
  logic               i_pix_valid = 1'b0;
  logic signed [15:0] i_pix_x = '0;
  logic signed [15:0] i_pix_y = '0;
  logic [7:0]         i_pix_r = '0;
  logic [7:0]         i_pix_g = '0;
  logic [7:0]         i_pix_b = '0;
  logic               i_clear_stats = 1'b0;
  logic               i_mem_ready = 1'b0;
  logic               o_mem_valid;
  logic [AB-1:0]      o_mem_addr;
  logic [15:0]        o_mem_data;
  logic               o_overflow;
  logic [15:0]        o_drop_count;
  logic               o_idle;

  always #5 i_clk = ~i_clk;

  frame_buffer_writer #(
    .FB_WIDTH (W), .FB_HEIGHT (H), .ADDR_BITS (AB),
    .BASE_ADDR (BA), .DEPTH (D)
  ) dut (
    .i_clk (i_clk), .i_reset_n (i_reset_n),
    .i_pix_valid (i_pix_valid), .i_pix_x (i_pix_x), .i_pix_y (i_pix_y),
    .i_pix_r (i_pix_r), .i_pix_g (i_pix_g), .i_pix_b (i_pix_b),
    .i_clear_stats (i_clear_stats),
    .o_mem_valid (o_mem_valid), .i_mem_ready (i_mem_ready),
    .o_mem_addr (o_mem_addr), .o_mem_data (o_mem_data),
    .o_overflow (o_overflow), .o_drop_count (o_drop_count),
    .o_idle (o_idle)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: each stored pixel remembers the edge it entered storage;
  // it can be presented one edge later, in arrival order.
  typedef struct {
    int addr;
    int data;
    int t;
  } px_t;

  px_t q[$];
  px_t m_s1;
  bit  m_keep = 0;
  bit  m_ovf  = 0;
  int  m_cnt  = 0;
  int  cyc    = 0;

  function automatic px_t mk(input int x, input int y,
                             input int r, input int g, input int b);
    px_t p;
    p.addr = (BA + y * W + x) & ((1 << AB) - 1);
    p.data = (r / 8) * 2048 + (g / 4) * 32 + (b / 8);
    p.t    = 0;
    return p;
  endfunction

  function automatic bit in_rng(input int x, input int y);
    return x >= 0 && x < W && y >= 0 && y < H;
  endfunction

  function automatic bit exp_valid();
    return q.size() > 0 && q[0].t < cyc - 1;
  endfunction

  always @(posedge i_clk or negedge i_reset_n) begin
    bit xfer;
    bit drop;
    int sz;
    if (!i_reset_n) begin
      q.delete();
      m_keep = 0;
      m_ovf  = 0;
      m_cnt  = 0;
    end else begin
      sz   = q.size();
      xfer = exp_valid() && i_mem_ready;
      if (xfer) void'(q.pop_front());
      drop = m_keep && sz == D + 1 && !xfer;
      if (m_keep && !drop) begin
        m_s1.t = cyc;
        q.push_back(m_s1);
      end
      if (i_clear_stats) begin
        m_ovf = 0;
        m_cnt = 0;
      end else if (drop) begin
        m_ovf = 1;
        if (m_cnt < 65535) m_cnt++;
      end
`ifdef FBW_BOUNDS_CHECK_EN
      m_keep = i_pix_valid && in_rng(int'(i_pix_x), int'(i_pix_y));
`else
      m_keep = i_pix_valid;
`endif
      m_s1 = mk(int'(i_pix_x), int'(i_pix_y),
                int'(i_pix_r), int'(i_pix_g), int'(i_pix_b));
      cyc++;
    end
  end

  always @(negedge i_clk) begin
    chk("valid", int'(o_mem_valid), int'(exp_valid()));
    if (exp_valid() && o_mem_valid) begin
      chk("addr", int'(o_mem_addr), q[0].addr);
      chk("data", int'(o_mem_data), q[0].data);
    end
    chk("overflow", int'(o_overflow), int'(m_ovf));
    chk("drop_count", int'(o_drop_count), m_cnt);
    chk("idle", int'(o_idle), int'(!m_keep && q.size() == 0));
  end

  int ga[$];
  int gd[$];
  int gc[$];
  int tcyc = 0;

  always @(negedge i_clk) tcyc++;

  always @(posedge i_clk) begin
    if (i_reset_n && o_mem_valid && i_mem_ready) begin
      ga.push_back(int'(o_mem_addr));
      gd.push_back(int'(o_mem_data));
      gc.push_back(tcyc);
    end
  end

  task automatic drive(input int x, input int y,
                       input int r, input int g, input int b);
    @(negedge i_clk);
    i_pix_valid = 1'b1;
    i_pix_x = 16'(x);
    i_pix_y = 16'(y);
    i_pix_r = 8'(r);
    i_pix_g = 8'(g);
    i_pix_b = 8'(b);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge i_clk);
      i_pix_valid = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_valid", int'(o_mem_valid), 0);
    chk("rst_idle", int'(o_idle), 1);
    chk("rst_addr", int'(o_mem_addr), 0);
    i_reset_n = 1'b1;

    // single pixel
    i_mem_ready = 1'b1;
    ga.delete(); gd.delete(); gc.delete();
    drive(3, 2, 'hFF, 'h80, 'h08);
    gap(6);
    chk("single_n", ga.size(), 1);
    if (ga.size() == 1) begin
      chk("single_addr", ga[0], 643);
      chk("single_data", gd[0], 'hFC01);
    end
    chk("single_idle", int'(o_idle), 1);

    // stream of 8
    ga.delete(); gd.delete(); gc.delete();
    for (int i = 0; i < 8; i++) drive(i, 1, i * 30, i * 17, 255 - i);
    gap(6);
    chk("stream_n", ga.size(), 8);
    if (ga.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("stream_addr", ga[i], 320 + i);
        chk("stream_b2b", gc[i] - gc[0], i);
      end
    end

    // overflow: 18 pixels, 17 held
    i_mem_ready = 1'b0;
    ga.delete(); gd.delete(); gc.delete();
    for (int i = 0; i < 18; i++) drive(i, 10, i, 2 * i, 3 * i);
    gap(3);
    chk("ovf_cnt", int'(o_drop_count), 1);
    chk("ovf_flag", int'(o_overflow), 1);
    i_mem_ready = 1'b1;
    gap(24);
    chk("ovf_n", ga.size(), 17);
    if (ga.size() == 17) begin
      chk("ovf_first", ga[0], 3200);
      chk("ovf_last", ga[16], 3216);
    end
    @(negedge i_clk);
    i_clear_stats = 1'b1;
    @(negedge i_clk);
    i_clear_stats = 1'b0;
    chk("clr_cnt", int'(o_drop_count), 0);
    chk("clr_flag", int'(o_overflow), 0);

    // full FIFO with a push and pop on the same edge
    i_mem_ready = 1'b0;
    ga.delete(); gd.delete(); gc.delete();
    for (int i = 0; i < 17; i++) drive(i, 20, 255, 255, 255);
    gap(3);
    drive(100, 20, 0, 0, 0);
    @(negedge i_clk);
    i_pix_valid = 1'b0;
    i_mem_ready = 1'b1;
    gap(24);
    chk("fpp_cnt", int'(o_drop_count), 0);
    chk("fpp_n", ga.size(), 18);
    if (ga.size() == 18) chk("fpp_last", ga[17], 6500);

    // bounds
    ga.delete(); gd.delete(); gc.delete();
    drive(320, 0, 1, 2, 3);
    drive(-1, 5, 4, 5, 6);
    gap(6);
`ifdef FBW_BOUNDS_CHECK_EN
    chk("bnd_n", ga.size(), 0);
    chk("bnd_cnt", int'(o_drop_count), 0);
`else
    chk("bnd_n", ga.size(), 2);
    if (ga.size() == 2) begin
      chk("bnd_a0", ga[0], 320);
      chk("bnd_a1", ga[1], 1599);
    end
`endif

    // reset mid-stream with a drop on record
    i_mem_ready = 1'b0;
    for (int i = 0; i < 18; i++) drive(i, 30, 9, 9, 9);
    gap(3);
    chk("pre_rst_cnt", int'(o_drop_count), 1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(o_mem_valid), 0);
    chk("mid_rst_cnt", int'(o_drop_count), 0);
    chk("mid_rst_ovf", int'(o_overflow), 0);
    chk("mid_rst_idle", int'(o_idle), 1);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    ga.delete(); gd.delete(); gc.delete();
    i_mem_ready = 1'b1;
    drive(0, 0, 'h10, 'h20, 'h30);
    gap(6);
    chk("post_rst_n", ga.size(), 1);
    if (ga.size() == 1) chk("post_rst_addr", ga[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
